choose_arbiter: RTL and testbench



---
 rtl/choose_pkg.sv | 12 +
 rtl/choose.sv | 13 +
 rtl/choose_arbiter_rr_pick.sv | 30 +++
 rtl/choose_arbiter.sv | 145 ++++++++++++++
 tb/tb_choose_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/choose_pkg.sv
// Shared constants and FSM state type for the choose arbiter slice.
package choose_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/choose.sv
// Bitwise choose datapath: each result bit takes b where a is 1, else c.
module choose #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] chosen
);

  assign chosen = (a & b) | (~a & c);

endmodule

// File: rtl/choose_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      for (int unsigned j = 0; j < N_REQ; j++) begin
        // j is the requester sitting k slots above ptr, modulo N_REQ
        if (!found && valid[j] &&
            ((int'(unsigned'(ptr)) + k == j) || (int'(unsigned'(ptr)) + k == j + N_REQ))) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/choose_arbiter.sv
// Round-robin arbiter sharing one choose datapath, single-entry result register.
// Optional per-requester saturating grant counters under CHOOSE_ARB_CNT_EN.
module choose_arbiter
  import choose_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = WORD_W,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_c,
  output logic                   resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic [ID_W-1:0]        resp_id,
`ifdef CHOOSE_ARB_CNT_EN
  output logic [N_REQ*CNT_W-1:0] grant_cnt,
`endif
  input  logic                   resp_ready
);

  arb_state_e        state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0]  resp_data_q, resp_data_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_found;
  logic              can_accept;
  logic              xfer;
  logic [WIDTH-1:0]  a_sel, b_sel, c_sel, chosen;

  rr_pick #(
    .N_REQ(N_REQ),
    .IDX_W(ID_W)
  ) u_pick (
    .valid(req_valid),
    .ptr  (ptr_q),
    .grant(pick_grant),
    .idx  (pick_idx),
    .found(pick_found)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    c_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_idx == ID_W'(i)) begin
        a_sel = req_a[i*WIDTH +: WIDTH];
        b_sel = req_b[i*WIDTH +: WIDTH];
        c_sel = req_c[i*WIDTH +: WIDTH];
      end
    end
  end

  choose #(
    .WIDTH(WIDTH)
  ) u_choose (
    .a     (a_sel),
    .b     (b_sel),
    .c     (c_sel),
    .chosen(chosen)
  );

  always_comb begin
    can_accept   = (state_q == ST_EMPTY) || resp_ready;
    // Grant is suppressed during reset so a coincident transfer cannot happen.
    req_ready    = (can_accept && pick_found && !rst) ? pick_grant : '0;
    xfer         = |(req_valid & req_ready);
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    ptr_d        = ptr_q;
    if (xfer) begin
      state_d      = ST_FULL;
      resp_valid_d = 1'b1;
      resp_data_d  = chosen;
      resp_id_d    = pick_idx;
      ptr_d        = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
    end else if (resp_valid_q && resp_ready) begin
      state_d      = ST_EMPTY;
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      ptr_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

`ifdef CHOOSE_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (xfer && req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_choose_arbiter.sv
// Scoreboard bench for choose_arbiter: directed scenarios plus randomized traffic.
module tb_choose_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
`ifdef CHOOSE_ARB_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  choose_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_id   (resp_id),
`ifdef CHOOSE_ARB_CNT_EN
    .grant_cnt (grant_cnt),
`endif
    .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       pend;
  bit         pend_v;
  bit         clr_at_edge;
  int         mptr;
  int         vectors;
  int         miscompares;
  logic [W-1:0] oa[N], ob[N], oc[N];

  // One clock cycle: apply inputs, predict the grant, and queue the expected result.
  task automatic step(input logic r, input logic [N-1:0] v, input logic rr);
    int           g;
    bit           can;
    logic [N-1:0] exp_ready;
    @(posedge clk);
    if (clr_at_edge) begin
      q.delete();
      mptr        = 0;
      clr_at_edge = 1'b0;
    end else if (pend_v) begin
      q.push_back(pend);
    end
    pend_v = 1'b0;
    #1;
    rst        = r;
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = oa[i];
      req_b[i*W +: W] = ob[i];
      req_c[i*W +: W] = oc[i];
    end
    #2;
    can = (q.size() == 0) || rr;
    g   = -1;
    if (!r && can) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(mptr + k) % N]) g = (mptr + k) % N;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    vectors++;
    if (req_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL req_ready t=%0t got=%b exp=%b", $time, req_ready, exp_ready);
    end
    if (g >= 0) begin
      pend.id   = 2'(g);
      pend.data = (oa[g] & ob[g]) | (~oa[g] & oc[g]);
      pend_v    = 1'b1;
      mptr      = (g + 1) % N;
    end
    if (r) clr_at_edge = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (resp_valid !== (q.size() != 0)) begin
        miscompares++;
        $display("FAIL resp_valid t=%0t got=%b exp=%b", $time, resp_valid, q.size() != 0);
      end
      if (resp_valid === 1'b1 && q.size() != 0) begin
        vectors++;
        if (resp_data !== q[0].data || resp_id !== q[0].id) begin
          miscompares++;
          $display("FAIL resp t=%0t got data=%h id=%0d exp data=%h id=%0d",
                   $time, resp_data, resp_id, q[0].data, q[0].id);
        end
        if (resp_ready === 1'b1) void'(q.pop_front());
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    pend_v      = 1'b0;
    clr_at_edge = 1'b0;
    mptr        = 0;
    rst         = 1'b1;
    req_valid   = '0;
    resp_ready  = 1'b0;
    req_a       = '0;
    req_b       = '0;
    req_c       = '0;
    for (int i = 0; i < N; i++) begin
      oa[i] = '0; ob[i] = '0; oc[i] = '0;
    end
    step(1'b1, 4'b0000, 1'b0);
    step(1'b1, 4'b0000, 1'b0);

    // single request from r0
    oa[0] = 8'h0C; ob[0] = 8'h0E; oc[0] = 8'h08;
    step(1'b0, 4'b0001, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // all four valid, consumer always ready
    step(1'b1, 4'b0000, 1'b0);
    oa[0] = 8'hFF; ob[0] = 8'h00; oc[0] = 8'hFF;
    oa[1] = 8'h00; ob[1] = 8'h06; oc[1] = 8'h64;
    oa[2] = 8'h0C; ob[2] = 8'h0E; oc[2] = 8'h08;
    oa[3] = 8'hF0; ob[3] = 8'hAA; oc[3] = 8'h55;
    repeat (4) step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // backpressure: held result must stay put, then pop and push together
    step(1'b0, 4'b1111, 1'b0);
    repeat (5) step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // wrap-around from ptr=3 with only r3 and r1 valid
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 1'b1);
    repeat (2) step(1'b0, 4'b1010, 1'b1);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // reset while full with requests pending
    step(1'b0, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b0, 4'b1111, 1'b1);
    step(1'b0, 4'b0000, 1'b1);

    // randomized traffic
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        oa[i] = 8'($urandom); ob[i] = 8'($urandom); oc[i] = 8'($urandom);
      end
      step(($urandom_range(0, 99) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end

`ifdef CHOOSE_ARB_CNT_EN
    step(1'b1, 4'b0000, 1'b0);
    repeat (70000) step(1'b0, 4'b0100, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    for (int i = 0; i < N; i++) begin
      logic [15:0] exp_cnt;
      exp_cnt = (i == 2) ? 16'hFFFF : 16'h0000;
      vectors++;
      if (grant_cnt[i*16 +: 16] !== exp_cnt) begin
        miscompares++;
        $display("FAIL grant_cnt[%0d] got=%h exp=%h", i, grant_cnt[i*16 +: 16], exp_cnt);
      end
    end
`endif

    repeat (3) step(1'b0, 4'b0000, 1'b1);
    @(posedge clk);
    #7;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
